// File: rtl/aes_decrypt.sv
// Iterative AES-128 inverse cipher: one round per clock, internal key expansion
// into an 11-entry round-key file, optional one-entry expanded-key cache.

module gf_inv8 (
  input  logic [7:0] i_a,
  output logic [7:0] o_inv
);
  logic [7:0] w_acc;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); 0 maps to 0 naturally
  always_comb begin
    w_acc = i_a;
    for (int i = 0; i < 6; i++) w_acc = gmul(gmul(w_acc, w_acc), i_a);
    o_inv = gmul(w_acc, w_acc);
  end
endmodule

module fwd_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);
  logic [7:0] w_inv;

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  gf_inv8 u_inv (.i_a(i_a), .o_inv(w_inv));
  assign o_s = w_inv ^ rotl(w_inv, 1) ^ rotl(w_inv, 2) ^ rotl(w_inv, 3) ^ rotl(w_inv, 4) ^ 8'h63;
endmodule

module inv_sbox (
  input  logic [7:0] i_s,
  output logic [7:0] o_a
);
  logic [7:0] w_pre;

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  assign w_pre = rotl(i_s, 1) ^ rotl(i_s, 3) ^ rotl(i_s, 6) ^ 8'h05;
  gf_inv8 u_inv (.i_a(w_pre), .o_inv(o_a));
endmodule

module aes_decrypt #(
  parameter int KEY_CACHE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] datain,
  input  logic [127:0] key,
  input  logic         in_valid,
  output logic [127:0] dataout,
  output logic         out_valid,
  output logic         aes_busy
);
  typedef enum logic [2:0] {IDLE, KEXP, ADDK, ROUND, FINAL} st_t;

  st_t          r_st, w_nxt;
  logic [127:0] r_rk [0:10];
  logic [127:0] r_state, r_key_cached;
  logic         r_cache_valid;
  logic [3:0]   r_ctr;

  logic         w_accept, w_hit;
  logic [127:0] w_rk_prev, w_rk_rnd, w_rk_next;
  logic [127:0] w_isr, w_isb, w_ark, w_imc;
  logic [31:0]  w_rot, w_sub, w_t, w_n0, w_n1, w_n2, w_n3;
  logic [7:0]   w_rcon;

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    x4 = {x2[6:0], 1'b0} ^ (x2[7] ? 8'h1b : 8'h00);
    x8 = {x4[6:0], 1'b0} ^ (x4[7] ? 8'h1b : 8'h00);
    return (c[3] ? x8 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[0] ? a : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
            gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
            gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
            gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)};
  endfunction

  // byte index 4*c+r, byte 0 in the MSBs; row r rotates right by r
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  assign w_accept = in_valid && (r_st == IDLE);
  assign w_hit    = (KEY_CACHE != 0) && r_cache_valid && (key == r_key_cached);
  assign aes_busy = (r_st != IDLE);

  always_comb begin
    w_rk_prev = r_rk[0];
    w_rk_rnd  = r_rk[0];
    for (int i = 1; i <= 10; i++) if (r_ctr == 4'(i)) w_rk_prev = r_rk[i-1];
    for (int i = 1; i <= 9; i++) if (r_st == ROUND && r_ctr == 4'(i)) w_rk_rnd = r_rk[i];
  end

  always_comb begin
    case (r_ctr)
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  assign w_rot = {w_rk_prev[23:0], w_rk_prev[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_ksb
    fwd_sbox u_sb (.i_a(w_rot[8*g +: 8]), .o_s(w_sub[8*g +: 8]));
  end

  always_comb begin
    w_t       = w_sub ^ {w_rcon, 24'h0};
    w_n0      = w_rk_prev[127:96] ^ w_t;
    w_n1      = w_rk_prev[95:64] ^ w_n0;
    w_n2      = w_rk_prev[63:32] ^ w_n1;
    w_n3      = w_rk_prev[31:0] ^ w_n2;
    w_rk_next = {w_n0, w_n1, w_n2, w_n3};
  end

  // shared inverse round datapath; FINAL taps it before InvMixColumns
  assign w_isr = inv_shift_rows(r_state);

  for (genvar g = 0; g < 16; g++) begin : g_isb
    inv_sbox u_isb (.i_s(w_isr[8*g +: 8]), .o_a(w_isb[8*g +: 8]));
  end

  assign w_ark = w_isb ^ w_rk_rnd;

  for (genvar g = 0; g < 4; g++) begin : g_imc
    assign w_imc[32*g +: 32] = inv_mix_col(w_ark[32*g +: 32]);
  end

  always_comb begin
    w_nxt = r_st;
    case (r_st)
      IDLE:    if (w_accept) w_nxt = w_hit ? ADDK : KEXP;
      KEXP:    if (r_ctr == 4'd10) w_nxt = ADDK;
      ADDK:    w_nxt = ROUND;
      ROUND:   if (r_ctr == 4'd1) w_nxt = FINAL;
      FINAL:   w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_st <= IDLE;
    else       r_st <= w_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= '0;
      r_ctr         <= '0;
      r_cache_valid <= 1'b0;
      r_key_cached  <= '0;
      dataout       <= '0;
      out_valid     <= 1'b0;
      for (int i = 0; i <= 10; i++) r_rk[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      case (r_st)
        IDLE: if (w_accept) begin
          r_state <= datain;
          r_rk[0] <= key;
          r_ctr   <= 4'd1;
        end
        KEXP: begin
          for (int i = 1; i <= 10; i++) if (r_ctr == 4'(i)) r_rk[i] <= w_rk_next;
          r_ctr <= r_ctr + 4'd1;
          if (r_ctr == 4'd10) begin
            r_key_cached  <= r_rk[0];
            r_cache_valid <= 1'b1;
          end
        end
        ADDK: begin
          r_state <= r_state ^ r_rk[10];
          r_ctr   <= 4'd9;
        end
        ROUND: begin
          r_state <= w_imc;
          r_ctr   <= r_ctr - 4'd1;
        end
        FINAL: begin
          dataout   <= w_ark;
          out_valid <= 1'b1;
          r_ctr     <= 4'd0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_decrypt.sv
// Bench for aes_decrypt: byte-level AES reference (encrypt + inverse cipher),
// cycle timing model with key-cache tracking, FIPS-197 directed vectors, loopback.

module tb_aes_decrypt;
  logic         clk, reset, in_valid;
  logic [127:0] datain, key;
  logic [127:0] dataout, nc_dataout;
  logic         out_valid, aes_busy, nc_out_valid, nc_busy;

  int n_pass = 0, n_tot = 0;
  bit chk_en = 0;

  logic [7:0] sb [256];
  logic [7:0] isb [256];

  localparam logic [127:0] KA  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT3 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT3 = 128'h3925841d02dc09fbdc118597196a0b32;

  aes_decrypt #(.KEY_CACHE(1)) u_dut (
    .clk(clk), .reset(reset), .datain(datain), .key(key), .in_valid(in_valid),
    .dataout(dataout), .out_valid(out_valid), .aes_busy(aes_busy));

  aes_decrypt #(.KEY_CACHE(0)) u_nc (
    .clk(clk), .reset(reset), .datain(datain), .key(key), .in_valid(in_valid),
    .dataout(nc_dataout), .out_valid(nc_out_valid), .aes_busy(nc_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // ---------------- reference AES ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] bget(input logic [127:0] x, input int i);
    return x[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] sub128(input logic [127:0] x, input bit inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv ? isb[bget(x, i)] : sb[bget(x, i)];
    return o;
  endfunction

  function automatic logic [127:0] shift128(input logic [127:0] x, input bit inv);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!inv) o[127-8*(r+4*c) -: 8] = bget(x, r + 4*((c+r)%4));
        else      o[127-8*(r+4*((c+r)%4)) -: 8] = bget(x, r + 4*c);
    return o;
  endfunction

  function automatic logic [127:0] mix128(input logic [127:0] x, input bit inv);
    logic [127:0] o;
    logic [7:0] m [4];
    logic [7:0] acc;
    if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(m[(j-r+4)%4], bget(x, j + 4*c));
        o[127-8*(r+4*c) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [1407:0] kexp(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [1407:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) o[1407-32*i -: 32] = w[i];
    return o;
  endfunction

  function automatic logic [127:0] rkey(input logic [1407:0] ks, input int n);
    return ks[1407-128*n -: 128];
  endfunction

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [127:0] k);
    logic [1407:0] ks;
    logic [127:0] s;
    ks = kexp(k);
    s = pt ^ rkey(ks, 0);
    for (int r = 1; r <= 9; r++) s = mix128(shift128(sub128(s, 0), 0), 0) ^ rkey(ks, r);
    return shift128(sub128(s, 0), 0) ^ rkey(ks, 10);
  endfunction

  function automatic logic [127:0] model_decrypt(input logic [127:0] ct, input logic [127:0] k);
    logic [1407:0] ks;
    logic [127:0] s;
    ks = kexp(k);
    s = ct ^ rkey(ks, 10);
    for (int r = 9; r >= 1; r--) s = mix128(sub128(shift128(s, 1), 1) ^ rkey(ks, r), 1);
    return sub128(shift128(s, 1), 1) ^ rkey(ks, 0);
  endfunction

  // ---------------- timing model: [0] cached DUT, [1] uncached DUT ----------------
  logic         m_busy [2];
  logic         m_ov   [2];
  logic         m_cv   [2];
  logic [127:0] m_dout [2];
  logic [127:0] m_exp  [2];
  logic [127:0] m_key  [2];
  int           m_cnt  [2];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        m_busy[c] <= 1'b0; m_ov[c] <= 1'b0; m_cv[c] <= 1'b0;
        m_dout[c] <= '0; m_exp[c] <= '0; m_key[c] <= '0; m_cnt[c] <= 0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        m_ov[c] <= 1'b0;
        if (m_busy[c]) begin
          if (m_cnt[c] == 1) begin
            m_busy[c] <= 1'b0;
            m_ov[c]   <= 1'b1;
            m_dout[c] <= m_exp[c];
          end
          m_cnt[c] <= m_cnt[c] - 1;
        end else if (in_valid) begin
          m_busy[c] <= 1'b1;
          m_cnt[c]  <= (c == 0 && m_cv[c] && key == m_key[c]) ? 11 : 21;
          m_exp[c]  <= model_decrypt(datain, key);
          m_cv[c]   <= 1'b1;
          m_key[c]  <= key;
        end
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (chk_en) begin
      check("busy",    128'(aes_busy),     128'(m_busy[0]));
      check("ovalid",  128'(out_valid),    128'(m_ov[0]));
      check("dout",    dataout,            m_dout[0]);
      check("nc_busy", 128'(nc_busy),      128'(m_busy[1]));
      check("nc_ov",   128'(nc_out_valid), 128'(m_ov[1]));
      check("nc_dout", nc_dataout,         m_dout[1]);
    end
  end

  // ---------------- driver ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((aes_busy || nc_busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", 128'(aes_busy | nc_busy), 128'(0));
  endtask

  task automatic send(input logic [127:0] k, input logic [127:0] ct,
                      input logic [127:0] exp_pt, input int exp_lat, input string nm);
    int n;
    bit got;
    wait_idle();
    key = k; datain = ct; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0; got = 0;
    while (!got && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) got = 1;
    end
    check({nm, "_lat"}, 128'(got ? n : 999), 128'(exp_lat));
    check({nm, "_data"}, dataout, exp_pt);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] inv, s;
    logic [127:0] k, pt, ct, lastk;
    int pulses, p1, p2;

    reset = 1'b1; in_valid = 1'b0; key = '0; datain = '0;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sb[x] = s;
      isb[s] = 8'(x);
    end

    // pin the reference model with FIPS-197 vectors
    check("pin_sbox00", 128'(sb[0]), 128'h63);
    check("pin_sbox53", 128'(sb[8'h53]), 128'hed);
    check("pin_enc1", model_encrypt(PT1, KA), CT1);
    check("pin_dec1", model_decrypt(CT1, KA), PT1);
    check("pin_enc3", model_encrypt(PT3, KB), CT3);
    check("pin_rk10", rkey(kexp(KB), 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_en = 1;
    @(posedge clk); #1;
    check("rst_dout", dataout, 128'h0);
    check("rst_ov",   128'(out_valid), 128'h0);
    check("rst_busy", 128'(aes_busy), 128'h0);

    send(KA, CT1, PT1, 21, "t1_miss");
    send(KA, CT1, PT1, 11, "t2_hit");
    send(KB, CT3, PT3, 21, "t3_miss");

    // in_valid held high with datain changing every cycle
    wait_idle();
    key = KA; datain = CT1; in_valid = 1'b1;
    pulses = 0; p1 = 0; p2 = 0;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      datain = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      if (out_valid) begin
        pulses++;
        if (pulses == 1) p1 = n;
        if (pulses == 2) p2 = n;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("t4_pulses", 128'(pulses), 128'(2));
    check("t4_first",  128'(p1), 128'(21));
    check("t4_second", 128'(p2), 128'(33));

    // reset in the middle of key expansion
    wait_idle();
    key = KB; datain = CT3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_busy_cleared", 128'(aes_busy), 128'h0);
    pulses = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    check("t5_no_ov", 128'(pulses), 128'(0));
    send(KA, CT1, PT1, 21, "t5_resub");

    // loopback through the reference encryptor
    lastk = KA;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(9) < 3) k = lastk;
      else k = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      ct = model_encrypt(pt, k);
      send(k, ct, pt, (k == lastk) ? 11 : 21, "loop");
      lastk = k;
    end

    wait_idle();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
